// File: rtl/pmd85_pkg.sv
// Shared PMD85 core definitions: ROM Pack geometry and the uploader state encoding.
package pmd85_pkg;

    typedef enum logic [1:0] {
        UPL_IDLE = 2'd0,
        UPL_REQ  = 2'd1,
        UPL_LAT  = 2'd2,
        UPL_DONE = 2'd3
    } upl_state_t;

    localparam int         ROM_PACK_ADDR_W    = 15;
    localparam int         ROM_PACK_INDEX     = 1;
    localparam logic [7:0] ROM_PACK_FILL_BYTE = 8'hFF;

endpackage

// File: rtl/rmm_uploader.sv
// Serves hps_io upload reads from the ROM Pack RAM so the OSD can save the pack back to SD.
//
// state | meaning
// IDLE  | waiting for an ioctl_rd strobe while the ROM Pack session is selected
// REQ   | holding mem_req/mem_addr until the arbiter grants the slot
// LAT   | counting down the RAM read latency after the grant
// DONE  | data latched on ioctl_din; drop ioctl_wait and count the byte
module rmm_uploader
    import pmd85_pkg::*;
#(
    parameter int         ADDR_W     = ROM_PACK_ADDR_W,
    parameter int         PACK_INDEX = ROM_PACK_INDEX,
    parameter int         RD_LATENCY = 2,
    parameter logic [7:0] FILL_BYTE  = ROM_PACK_FILL_BYTE
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              upload_active,
    output logic [ADDR_W:0]   bytes_served
);

    localparam logic [ADDR_W:0] BYTES_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] BYTES_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [2:0]      LAT_LOAD  = 3'(RD_LATENCY - 1);

    upl_state_t  state_q, state_d;
    logic [2:0]  lat_cnt;
    logic [24:0] addr_hi;
    logic        sel, sel_q, sel_rise;
    logic        accept, out_of_range, abort, take_gnt, lat_fin, lat_step, finish;

    assign sel           = ioctl_upload & (ioctl_index == 8'(PACK_INDEX));
    assign sel_rise      = sel & ~sel_q;
    assign upload_active = sel_q;
    assign addr_hi       = ioctl_addr >> ADDR_W;
    assign out_of_range  = |addr_hi;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state_q <= UPL_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            UPL_IDLE: if (accept)        state_d = out_of_range ? UPL_DONE : UPL_REQ;
            UPL_REQ:  if (abort)         state_d = UPL_IDLE;
                      else if (take_gnt) state_d = UPL_LAT;
            UPL_LAT:  if (abort)         state_d = UPL_IDLE;
                      else if (lat_fin)  state_d = UPL_DONE;
            UPL_DONE:                    state_d = UPL_IDLE;
            default:                     state_d = UPL_IDLE;
        endcase
    end

    // Abort wins over a grant in the same cycle so a late slot is simply dropped.
    always_comb begin
        accept   = (state_q == UPL_IDLE) & ioctl_rd & sel;
        abort    = ((state_q == UPL_REQ) | (state_q == UPL_LAT)) & ~sel;
        take_gnt = (state_q == UPL_REQ) & sel & mem_gnt;
        lat_fin  = (state_q == UPL_LAT) & sel & (lat_cnt == 3'd0);
        lat_step = (state_q == UPL_LAT) & sel & (lat_cnt != 3'd0);
        finish   = (state_q == UPL_DONE);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sel_q        <= 1'b0;
            ioctl_din    <= 8'h00;
            ioctl_wait   <= 1'b0;
            mem_req      <= 1'b0;
            mem_addr     <= '0;
            lat_cnt      <= 3'd0;
            bytes_served <= '0;
        end else begin
            sel_q <= sel;
            if (accept) begin
                ioctl_wait <= 1'b1;
                if (out_of_range) begin
                    ioctl_din <= FILL_BYTE;
                end else begin
                    mem_addr <= ioctl_addr[ADDR_W-1:0];
                    mem_req  <= 1'b1;
                end
            end
            if (take_gnt) begin
                mem_req <= 1'b0;
                lat_cnt <= LAT_LOAD;
            end
            if (lat_step) lat_cnt   <= lat_cnt - 3'd1;
            if (lat_fin)  ioctl_din <= mem_rdata;
            if (abort) begin
                mem_req    <= 1'b0;
                ioctl_wait <= 1'b0;
            end
            if (finish) begin
                ioctl_wait <= 1'b0;
                if (bytes_served != BYTES_MAX) bytes_served <= bytes_served + BYTES_ONE;
            end
            if (sel_rise) bytes_served <= '0;
        end
    end

endmodule

// File: tb/tb_rmm_uploader.sv
// Directed bench for rmm_uploader: a full-size instance plus an 8-bit-address instance for the sweep/saturation case.
module tb_rmm_uploader;

    localparam int RD_LAT    = 2;
    localparam int SM_RD_LAT = 1;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [24:0] sm_addr;
    logic        gnt_en, gnt_force;

    logic [7:0]  ioctl_din;
    logic        ioctl_wait, mem_req, mem_gnt, upload_active;
    logic [14:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [15:0] bytes_served;

    logic [7:0]  sm_din;
    logic        sm_wait, sm_req, sm_gnt, sm_active;
    logic [7:0]  sm_maddr;
    logic [7:0]  sm_rdata;
    logic [8:0]  sm_bytes;

    int n_checks = 0;
    int n_err    = 0;

    logic [14:0] g_addr = '0;
    int          g_cnt  = 0;
    logic [14:0] s_addr = '0;
    int          s_cnt  = 0;

    always #5 clk_sys = ~clk_sys;

    // Pack contents: address-derived pattern with one marked byte.
    function automatic logic [7:0] pat(input logic [14:0] a);
        if (a == 15'h0123) return 8'hA5;
        return a[7:0] ^ {a[14:8], 1'b0};
    endfunction

    // RAM models: data valid only in the cycle exactly RD_LATENCY after the granted cycle.
    assign mem_gnt   = (mem_req & gnt_en) | gnt_force;
    assign mem_rdata = (g_cnt == RD_LAT) ? pat(g_addr) : ~pat(g_addr);
    assign sm_gnt    = sm_req;
    assign sm_rdata  = (s_cnt == SM_RD_LAT) ? pat(s_addr) : ~pat(s_addr);

    always @(posedge clk_sys) begin
        if (mem_gnt && mem_req) begin
            g_addr <= mem_addr;
            g_cnt  <= 1;
        end else if (g_cnt != 0 && g_cnt < 15) begin
            g_cnt <= g_cnt + 1;
        end
        if (sm_gnt) begin
            s_addr <= {7'd0, sm_maddr};
            s_cnt  <= 1;
        end else if (s_cnt != 0 && s_cnt < 15) begin
            s_cnt <= s_cnt + 1;
        end
    end

    rmm_uploader #(.RD_LATENCY(RD_LAT)) u_dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .ioctl_upload  (ioctl_upload),
        .ioctl_index   (ioctl_index),
        .ioctl_rd      (ioctl_rd),
        .ioctl_addr    (ioctl_addr),
        .ioctl_din     (ioctl_din),
        .ioctl_wait    (ioctl_wait),
        .mem_req       (mem_req),
        .mem_gnt       (mem_gnt),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .upload_active (upload_active),
        .bytes_served  (bytes_served)
    );

    rmm_uploader #(.ADDR_W(8), .RD_LATENCY(SM_RD_LAT)) u_small (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .ioctl_upload  (ioctl_upload),
        .ioctl_index   (ioctl_index),
        .ioctl_rd      (ioctl_rd),
        .ioctl_addr    (sm_addr),
        .ioctl_din     (sm_din),
        .ioctl_wait    (sm_wait),
        .mem_req       (sm_req),
        .mem_gnt       (sm_gnt),
        .mem_addr      (sm_maddr),
        .mem_rdata     (sm_rdata),
        .upload_active (sm_active),
        .bytes_served  (sm_bytes)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One read strobe on both instances; returns cycles the main ioctl_wait stayed high.
    task automatic rd(input logic [24:0] a, input logic [24:0] sa, output int wcyc, output logic saw_req);
        ioctl_addr = a;
        sm_addr    = sa;
        ioctl_rd   = 1'b1;
        saw_req    = 1'b0;
        tick();
        ioctl_rd = 1'b0;
        wcyc     = 0;
        for (int i = 0; i < 200 && (ioctl_wait || sm_wait); i++) begin
            if (ioctl_wait) wcyc++;
            if (mem_req) saw_req = 1'b1;
            tick();
        end
        check("rd_timeout", {30'd0, ioctl_wait, sm_wait}, 32'd0);
    endtask

    initial begin
        int          w;
        logic        sr;
        logic [14:0] a;

        reset_n      = 1'b0;
        ioctl_upload = 1'b0;
        ioctl_index  = 8'd1;
        ioctl_rd     = 1'b0;
        ioctl_addr   = '0;
        sm_addr      = '0;
        gnt_en       = 1'b1;
        gnt_force    = 1'b0;
        tick();
        tick();

        check("rst_din",    ioctl_din, 8'h00);
        check("rst_wait",   ioctl_wait, 1'b0);
        check("rst_req",    mem_req, 1'b0);
        check("rst_maddr",  mem_addr, 15'h0);
        check("rst_active", upload_active, 1'b0);
        check("rst_bytes",  bytes_served, 16'h0);

        reset_n = 1'b1;
        tick();

        // Wrong index: session open but not on the ROM Pack.
        ioctl_index  = 8'd0;
        ioctl_upload = 1'b1;
        tick();
        check("wrongidx_active", upload_active, 1'b0);
        rd(25'h10, 25'h10, w, sr);
        check("wrongidx_wait", w, 0);
        check("wrongidx_req",  sr, 1'b0);
        check("wrongidx_din",  ioctl_din, 8'h00);

        ioctl_index = 8'd1;
        tick();
        check("sel_active", upload_active, 1'b1);

        rd(25'h0123, 25'h23, w, sr);
        check("inrange_wait",  w, 4);
        check("inrange_din",   ioctl_din, 8'hA5);
        check("inrange_bytes", bytes_served, 16'd1);
        check("small_din",     sm_din, 8'h23);

        rd(25'h8000, 25'h100, w, sr);
        check("oor_wait",     w, 1);
        check("oor_din",      ioctl_din, 8'hFF);
        check("oor_req",      sr, 1'b0);
        check("oor_bytes",    bytes_served, 16'd2);
        check("small_oordin", sm_din, 8'hFF);
        tick();
        tick();
        check("din_hold", ioctl_din, 8'hFF);

        // Grant withheld for 10 cycles.
        gnt_en     = 1'b0;
        ioctl_addr = 25'h7FFF;
        sm_addr    = 25'h05;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("stall_hold", {16'd0, mem_req, mem_addr}, {16'd0, 1'b1, 15'h7FFF});
            tick();
        end
        gnt_en = 1'b1;
        tick();
        check("stall_reqdrop", mem_req, 1'b0);
        tick();
        check("stall_early",   ioctl_din, 8'hFF);
        tick();
        check("stall_data",    ioctl_din, 8'h01);
        check("stall_waithi",  ioctl_wait, 1'b1);
        tick();
        check("stall_waitlo",  ioctl_wait, 1'b0);
        check("stall_bytes",   bytes_served, 16'd3);

        // Abort in REQ with a grant arriving in the abort cycle and another one later.
        gnt_en     = 1'b0;
        ioctl_addr = 25'h0200;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        check("abort_inreq", mem_req, 1'b1);
        ioctl_upload = 1'b0;
        gnt_en       = 1'b1;
        tick();
        check("abort_req",   mem_req, 1'b0);
        check("abort_wait",  ioctl_wait, 1'b0);
        check("abort_din",   ioctl_din, 8'h01);
        check("abort_bytes", bytes_served, 16'd3);
        gnt_force = 1'b1;
        tick();
        gnt_force = 1'b0;
        tick();
        tick();
        tick();
        check("late_gnt", {ioctl_din, ioctl_wait, mem_req, upload_active}, {8'h01, 1'b0, 1'b0, 1'b0});
        check("late_bytes", bytes_served, 16'd3);

        // Async reset in the middle of LAT.
        ioctl_upload = 1'b1;
        tick();
        tick();
        check("reopen_clear", bytes_served, 16'd0);
        ioctl_addr = 25'h0123;
        sm_addr    = 25'h0;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        tick();
        check("midlat_wait", ioctl_wait, 1'b1);
        reset_n = 1'b0;
        #1;
        check("async_rst", {ioctl_din, ioctl_wait, mem_req, mem_addr, upload_active, bytes_served},
                           {8'h00, 1'b0, 1'b0, 15'h0, 1'b0, 16'h0});
        tick();
        #2;
        reset_n = 1'b1;
        tick();
        check("post_rst_idle", {ioctl_wait, mem_req}, 2'b00);
        rd(25'h0123, 25'h0, w, sr);
        check("post_rst_wait", w, 4);
        check("post_rst_din",  ioctl_din, 8'hA5);
        check("post_rst_bytes", bytes_served, 16'd1);

        // Sweep: sparse across the full pack on the main instance, complete on the 8-bit one.
        ioctl_upload = 1'b0;
        tick();
        ioctl_upload = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 256; k++) begin
            a = 15'(k * 128 + (k & 127));
            rd({10'd0, a}, 25'(k), w, sr);
            check("sweep_main",  ioctl_din, pat(a));
            check("sweep_small", sm_din, pat(15'(k)));
        end
        check("sweep_bytes",    bytes_served, 16'd256);
        check("sweep_sm_bytes", sm_bytes, 9'h100);
        rd(25'h40, 25'h7, w, sr);
        check("sat_small_din", sm_din, 8'h07);
        rd(25'h41, 25'h1FF, w, sr);
        check("sat_small_oor", sm_din, 8'hFF);
        check("sat_sm_bytes",  sm_bytes, 9'h100);
        check("sat_bytes",     bytes_served, 16'd258);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
